// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO family.
// Pointers carry one extra wrap bit above the address bits.
package fifo_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 5;

  function automatic int ptr_width(input int addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/fifo_sync_ram.sv
// DEPTH x DATA_W storage: one write port and one registered read port.
// The read register holds its value when no read is requested.
module fifo_sync_ram #(
  parameter int DATA_W = fifo_pkg::DEF_DATA_W,
  parameter int ADDR_W = fifo_pkg::DEF_ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // NOTE: the storage array has no reset; stale entries are never visible
  // because the pointers define which words are valid.
  always_ff @(posedge clock) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy count, almost flags and
// registered read-valid. Define FIFO_SYNC_ERR_EN for sticky overflow/underflow ports.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int AF_LEVEL = 28,
  parameter int AE_LEVEL = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                write,
  input  logic [DATA_W-1:0]   datain,
  input  logic                read,
  output logic [DATA_W-1:0]   dataout,
  output logic                dataout_valid,
  output logic                full,
  output logic                empty,
  output logic                almost_full,
  output logic                almost_empty,
  output logic [ADDR_W:0]     count
`ifdef FIFO_SYNC_ERR_EN
  ,
  output logic                overflow,
  output logic                underflow
`endif
);

  localparam int PTR_W = ptr_width(ADDR_W);
  localparam logic [PTR_W-1:0] AF_LVL = PTR_W'(AF_LEVEL);
  localparam logic [PTR_W-1:0] AE_LVL = PTR_W'(AE_LEVEL);

  logic [PTR_W-1:0] w_ptr_q, w_ptr_d;
  logic [PTR_W-1:0] r_ptr_q, r_ptr_d;
  logic             valid_q, valid_d;
  logic             write_en, read_en;

  // Status is derived from the registered pointers only, so it is stable all cycle.
  assign count        = w_ptr_q - r_ptr_q;
  assign empty        = (w_ptr_q == r_ptr_q);
  assign full         = (w_ptr_q[PTR_W-1] != r_ptr_q[PTR_W-1]) &&
                        (w_ptr_q[ADDR_W-1:0] == r_ptr_q[ADDR_W-1:0]);
  assign almost_full  = (count >= AF_LVL);
  assign almost_empty = (count <= AE_LVL);

  assign write_en = write & ~full;
  assign read_en  = read & ~empty;

  always_comb begin
    w_ptr_d = w_ptr_q;
    r_ptr_d = r_ptr_q;
    valid_d = read_en;
    if (write_en) w_ptr_d = w_ptr_q + PTR_W'(1);
    if (read_en)  r_ptr_d = r_ptr_q + PTR_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clock) begin
    if (reset) begin
      w_ptr_q <= '0;
      r_ptr_q <= '0;
      valid_q <= 1'b0;
    end else begin
      w_ptr_q <= w_ptr_d;
      r_ptr_q <= r_ptr_d;
      valid_q <= valid_d;
    end
  end

  assign dataout_valid = valid_q;

  fifo_sync_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clock     (clock),
    .reset     (reset),
    .wr_en_i   (write_en),
    .wr_addr_i (w_ptr_q[ADDR_W-1:0]),
    .wr_data_i (datain),
    .rd_en_i   (read_en),
    .rd_addr_i (r_ptr_q[ADDR_W-1:0]),
    .rd_data_o (dataout)
  );

`ifdef FIFO_SYNC_ERR_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  always_comb begin
    overflow_d  = overflow_q  | (write & full);
    underflow_d = underflow_q | (read & empty);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  // Illegal requests are dropped by the write_en/read_en gating and not recorded.
`endif

endmodule

// File: tb/tb_fifo_sync_param.sv
// Randomised and directed bench for fifo_sync_param (DEPTH=4) against a queue model.
// Define FIFO_SYNC_ERR_EN to also check the sticky error ports.
module tb_fifo_sync_param;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 2;
  localparam int DEPTH  = 4;
  localparam int AF     = 3;
  localparam int AE     = 1;

  logic              clock = 1'b0;
  logic              reset;
  logic              write, read;
  logic [DATA_W-1:0] datain;
  logic [DATA_W-1:0] dataout;
  logic              dataout_valid, full, empty, almost_full, almost_empty;
  logic [ADDR_W:0]   count;
`ifdef FIFO_SYNC_ERR_EN
  logic              overflow, underflow;
`endif

  fifo_sync_param #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .AF_LEVEL (AF),
    .AE_LEVEL (AE)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .write         (write),
    .datain        (datain),
    .read          (read),
    .dataout       (dataout),
    .dataout_valid (dataout_valid),
    .full          (full),
    .empty         (empty),
    .almost_full   (almost_full),
    .almost_empty  (almost_empty),
    .count         (count)
`ifdef FIFO_SYNC_ERR_EN
    ,
    .overflow      (overflow),
    .underflow     (underflow)
`endif
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a queue of stored words plus the observable read register.
  logic [DATA_W-1:0] model_q[$];
  int                m_dout  = 0;
  int                m_valid = 0;
  int                m_ovf   = 0;
  int                m_udf   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    int n;
    n = model_q.size();
    check("count",         int'(count),         n);
    check("empty",         int'(empty),         int'(n == 0));
    check("full",          int'(full),          int'(n == DEPTH));
    check("almost_full",   int'(almost_full),   int'(n >= AF));
    check("almost_empty",  int'(almost_empty),  int'(n <= AE));
    check("dataout_valid", int'(dataout_valid), m_valid);
    check("dataout",       int'(dataout),       m_dout);
`ifdef FIFO_SYNC_ERR_EN
    check("overflow",      int'(overflow),      m_ovf);
    check("underflow",     int'(underflow),     m_udf);
`endif
  endtask

  // One clock cycle: drive on the falling edge, update model at the rising
  // edge, compare shortly after it.
  task automatic step(input bit w, input int d, input bit r, input bit rst);
    int n;
    @(negedge clock);
    write  = w;
    read   = r;
    datain = DATA_W'(d);
    reset  = rst;
    @(posedge clock);
    n = model_q.size();
    if (rst) begin
      model_q.delete();
      m_dout = 0; m_valid = 0; m_ovf = 0; m_udf = 0;
    end else begin
      if (w && n == DEPTH) m_ovf = 1;
      if (r && n == 0)     m_udf = 1;
      m_valid = 0;
      if (r && n > 0) begin
        m_dout  = int'(model_q.pop_front());
        m_valid = 1;
      end
      if (w && n < DEPTH) model_q.push_back(DATA_W'(d));
    end
    #1;
    check_all();
  endtask

  initial begin
    reset = 1'b1; write = 1'b0; read = 1'b0; datain = '0;

    // Reset then idle.
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    // Fill to full, then one dropped write.
    step(1, 'h11, 0, 0);
    step(1, 'h22, 0, 0);
    step(1, 'h33, 0, 0);
    step(1, 'h44, 0, 0);
    step(1, 'h55, 0, 0);

    // Drain, then one read on empty; dataout must hold the last word.
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);

    // Count 2, then simultaneous write+read across the pointer wrap.
    step(1, 'h60, 0, 0);
    step(1, 'h61, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 'h70 + i, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);

    // Empty with write+read together: write only.
    step(1, 'hA5, 1, 0);

    // Count 3 (with a full+write+read along the way), then reset with write held.
    step(1, 'hB1, 0, 0);
    step(1, 'hB2, 0, 0);
    step(1, 'hB3, 0, 0);
    step(1, 'hB4, 1, 0);
    step(1, 'hC0, 1, 1);
    step(0, 0, 0, 0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      step(bit'($urandom_range(0, 99) < 55), int'($urandom_range(0, 255)),
           bit'($urandom_range(0, 99) < 45), bit'($urandom_range(0, 99) < 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
